axi_read_router: RTL and testbench
==================================

Name: axi_read_router

Overview:
- Read-channel (AR/R) crossbar stage of the AXI interconnect.
- Sits directly upstream of the slaves: S0 instruction SRAM, S1 data SRAM, S2 decode-error default slave.
- Arbitrates two masters (M0 instruction fetch, M1 load/store), decodes ARADDR and forwards AR to one slave.
- Routes the returning R burst back to the granted master; one read transaction in flight system-wide.

Parameters:
- NM, 2, number of masters (fixed 2).
- NS, 3, number of slaves (S2 is the default slave).
- IDW, 4, master-side ID width.
- IDSW, 8, slave-side ID width; upper IDSW-IDW bits carry the master index.
- AW, 32, address width.
- DW, 32, data width.
- S0_BASE, 16'h0000, ARADDR[31:16] value selecting S0.
- S1_BASE, 16'h0001, ARADDR[31:16] value selecting S1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- ARID_M  in  NM x IDW  master AR id
- ARADDR_M  in  NM x AW  master AR address
- ARLEN_M  in  NM x 4  burst length-1
- ARSIZE_M  in  NM x 3  beat size
- ARBURST_M  in  NM x 2  burst type
- ARVALID_M  in  NM  master AR valid
- ARREADY_M  out  NM  master AR ready
- RID_M  out  NM x IDW  R id to master
- RDATA_M  out  NM x DW  R data to master
- RRESP_M  out  NM x 2  R response to master
- RLAST_M  out  NM  last beat to master
- RVALID_M  out  NM  R valid to master
- RREADY_M  in  NM  master R ready
- ARID_S  out  NS x IDSW  slave AR id {master index, ARID}
- ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S  out  NS x (AW, 4, 3, 2)  forwarded AR payload
- ARVALID_S  out  NS  slave AR valid
- ARREADY_S  in  NS  slave AR ready
- RID_S  in  NS x IDSW  slave R id
- RDATA_S  in  NS x DW  slave R data
- RRESP_S  in  NS x 2  slave R response
- RLAST_S  in  NS  slave last beat
- RVALID_S  in  NS  slave R valid
- RREADY_S  out  NS  R ready to slave

Behaviour:
- Registered state: FSM state, grant g (1b), sel (2b), last_grant (1b).
- Reset (rst=0, asynchronous): state=IDLE, g=0, sel=0, last_grant=1 (M0 wins first tie).
- All valid/ready outputs are 0 in reset and in IDLE; all data/id outputs are 0 whenever the associated valid is 0.
- IDLE:
  - If any ARVALID_M: grant the requester; if both request, grant the master != last_grant.
  - Register g and sel = decode(ARADDR_M[g][31:16]): S0_BASE->0, S1_BASE->1, anything else->2.
  - Next state ADDR. No ARREADY_M is asserted in IDLE.
- ADDR:
  - ARVALID_S[sel]=1 and ARREADY_M[g]=ARREADY_S[sel] (combinational).
  - Payload forwarded from master g; ARID_S[sel]={g zero-extended to IDSW-IDW bits, ARID_M[g]}.
  - On ARVALID_S[sel]&ARREADY_S[sel], go to DATA. Otherwise hold, with the payload stable (the master must hold it per AXI).
- DATA:
  - RVALID_M[g]=RVALID_S[sel]; RDATA/RRESP/RLAST_M[g] come from slave sel; RID_M[g]=RID_S[sel][IDW-1:0].
  - RREADY_S[sel]=RREADY_M[g].
  - On RVALID&RREADY&RLAST: state=IDLE, last_grant=g.
- Non-granted master and non-selected slaves see 0 on all outputs in every state.
- Minimum latency: ARVALID_M high at cycle 0 -> ARVALID_S high at cycle 1 -> earliest AR handshake at cycle 1.
- Back-to-back requests: a new grant is issued in the IDLE cycle following the RLAST handshake, so there is one idle bubble between transactions.
- Requests arriving during ADDR or DATA wait; they are never dropped.
- Slave-side R beats with RVALID_S on a non-selected slave are ignored (RREADY_S=0).
- DECERR from S2 is passed through unmodified.
- Reset asserted mid-burst: immediately returns to IDLE and all handshakes drop. Slaves are reset by the same rst.

Test Plan:
- M0 reads 0x0000_0040, ARLEN=3, S0 returns 4 beats -> ARVALID_S[0] at cycle 1, ARID_S[0]=8'h0_ID, 4 beats reach M0 with RID=ID, return to IDLE after RLAST.
- M1 reads 0x0001_0008, ARLEN=0 -> routed to S1, ARID_S[1]={4'h1,ID}, single beat with RLAST to M1, M0 sees RVALID_M=0.
- M1 reads 0x8000_0000, ARLEN=1 -> routed to S2, 2 beats with RRESP=2'b11 (DECERR), RDATA=0, RLAST on beat 2.
- M0 and M1 assert ARVALID in the same cycle, twice in a row -> after reset M0 is granted first, then M1; no request is lost.
- S0 holds ARREADY low 3 cycles and the master drops RREADY mid-burst -> ARVALID_S held, payload stable, no beat dropped or duplicated.
- Assert rst=0 during beat 2 of a 4-beat burst -> all valids 0 asynchronously; after release the next request is granted normally.

Source files
------------

// File: rtl/axi_read_router.sv
// AXI read-channel crossbar stage: arbitrates two masters onto three slaves
// (S2 is the decode-error default slave) with one read transaction in flight.
module axi_read_router #(
  parameter int          NM      = 2,
  parameter int          NS      = 3,
  parameter int          IDW     = 4,
  parameter int          IDSW    = 8,
  parameter int          AW      = 32,
  parameter int          DW      = 32,
  parameter logic [15:0] S0_BASE = 16'h0000,
  parameter logic [15:0] S1_BASE = 16'h0001
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NM-1:0][IDW-1:0]  i_ARID_M,
  input  logic [NM-1:0][AW-1:0]   i_ARADDR_M,
  input  logic [NM-1:0][3:0]      i_ARLEN_M,
  input  logic [NM-1:0][2:0]      i_ARSIZE_M,
  input  logic [NM-1:0][1:0]      i_ARBURST_M,
  input  logic [NM-1:0]           i_ARVALID_M,
  output logic [NM-1:0]           o_ARREADY_M,
  output logic [NM-1:0][IDW-1:0]  o_RID_M,
  output logic [NM-1:0][DW-1:0]   o_RDATA_M,
  output logic [NM-1:0][1:0]      o_RRESP_M,
  output logic [NM-1:0]           o_RLAST_M,
  output logic [NM-1:0]           o_RVALID_M,
  input  logic [NM-1:0]           i_RREADY_M,
  output logic [NS-1:0][IDSW-1:0] o_ARID_S,
  output logic [NS-1:0][AW-1:0]   o_ARADDR_S,
  output logic [NS-1:0][3:0]      o_ARLEN_S,
  output logic [NS-1:0][2:0]      o_ARSIZE_S,
  output logic [NS-1:0][1:0]      o_ARBURST_S,
  output logic [NS-1:0]           o_ARVALID_S,
  input  logic [NS-1:0]           i_ARREADY_S,
  input  logic [NS-1:0][IDSW-1:0] i_RID_S,
  input  logic [NS-1:0][DW-1:0]   i_RDATA_S,
  input  logic [NS-1:0][1:0]      i_RRESP_S,
  input  logic [NS-1:0]           i_RLAST_S,
  input  logic [NS-1:0]           i_RVALID_S,
  output logic [NS-1:0]           o_RREADY_S
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                r_state;
  logic                  r_g;
  logic [1:0]            r_sel;
  logic                  r_last_grant;

  logic                  w_gnt;
  logic [15:0]           w_req_hi;
  logic                  w_r_done;
  logic [IDSW-IDW-1:0]   w_gid;
  logic                  w_unused_rid;

  function automatic logic [1:0] f_decode(input logic [15:0] hi);
    if (hi == S0_BASE) return 2'd0;
    if (hi == S1_BASE) return 2'd1;
    return 2'd2;
  endfunction

  // On a tie the master that did not win last time gets the grant.
  assign w_gnt    = (i_ARVALID_M[0] & i_ARVALID_M[1]) ? ~r_last_grant : i_ARVALID_M[1];
  assign w_req_hi = i_ARADDR_M[w_gnt][AW-1:AW-16];
  assign w_r_done = i_RVALID_S[r_sel] & i_RREADY_M[r_g] & i_RLAST_S[r_sel];
  assign w_gid    = (IDSW-IDW)'(r_g);
  assign w_unused_rid = ^i_RID_S;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_g          <= 1'b0;
      r_sel        <= 2'd0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        IDLE: if (|i_ARVALID_M) begin
          r_g     <= w_gnt;
          r_sel   <= f_decode(w_req_hi);
          r_state <= ADDR;
        end
        ADDR: if (i_ARREADY_S[r_sel]) r_state <= DATA;
        DATA: if (w_r_done) begin
          r_state      <= IDLE;
          r_last_grant <= r_g;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Only the granted master / selected slave pair ever sees non-zero values.
  always_comb begin
    o_ARREADY_M = '0;
    o_RID_M     = '0;
    o_RDATA_M   = '0;
    o_RRESP_M   = '0;
    o_RLAST_M   = '0;
    o_RVALID_M  = '0;
    o_ARID_S    = '0;
    o_ARADDR_S  = '0;
    o_ARLEN_S   = '0;
    o_ARSIZE_S  = '0;
    o_ARBURST_S = '0;
    o_ARVALID_S = '0;
    o_RREADY_S  = '0;
    if (r_state == ADDR) begin
      o_ARVALID_S[r_sel] = 1'b1;
      o_ARID_S[r_sel]    = {w_gid, i_ARID_M[r_g]};
      o_ARADDR_S[r_sel]  = i_ARADDR_M[r_g];
      o_ARLEN_S[r_sel]   = i_ARLEN_M[r_g];
      o_ARSIZE_S[r_sel]  = i_ARSIZE_M[r_g];
      o_ARBURST_S[r_sel] = i_ARBURST_M[r_g];
      o_ARREADY_M[r_g]   = i_ARREADY_S[r_sel];
    end
    if (r_state == DATA) begin
      o_RVALID_M[r_g]  = i_RVALID_S[r_sel];
      o_RREADY_S[r_sel] = i_RREADY_M[r_g];
      if (i_RVALID_S[r_sel]) begin
        o_RID_M[r_g]   = i_RID_S[r_sel][IDW-1:0];
        o_RDATA_M[r_g] = i_RDATA_S[r_sel];
        o_RRESP_M[r_g] = i_RRESP_S[r_sel];
        o_RLAST_M[r_g] = i_RLAST_S[r_sel];
      end
    end
  end

endmodule

// File: tb/tb_axi_read_router.sv
// Bench for axi_read_router: behavioural masters/slaves plus a phase-level
// reference model of the single-outstanding round-robin router.
`timescale 1ns/1ps
module tb_axi_read_router;
  localparam int NM = 2, NS = 3, IDW = 4, IDSW = 8, AW = 32, DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NM-1:0][IDW-1:0]  arid_m;
  logic [NM-1:0][AW-1:0]   araddr_m;
  logic [NM-1:0][3:0]      arlen_m;
  logic [NM-1:0][2:0]      arsize_m;
  logic [NM-1:0][1:0]      arburst_m;
  logic [NM-1:0]           arvalid_m, arready_m, rlast_m, rvalid_m, rready_m;
  logic [NM-1:0][IDW-1:0]  rid_m;
  logic [NM-1:0][DW-1:0]   rdata_m;
  logic [NM-1:0][1:0]      rresp_m;
  logic [NS-1:0][IDSW-1:0] arid_s, rid_s;
  logic [NS-1:0][AW-1:0]   araddr_s;
  logic [NS-1:0][3:0]      arlen_s;
  logic [NS-1:0][2:0]      arsize_s;
  logic [NS-1:0][1:0]      arburst_s, rresp_s;
  logic [NS-1:0]           arvalid_s, arready_s, rlast_s, rvalid_s, rready_s;
  logic [NS-1:0][DW-1:0]   rdata_s;

  always #5 clk = ~clk;

  axi_read_router dut (
    .clk(clk), .rst(rst),
    .i_ARID_M(arid_m), .i_ARADDR_M(araddr_m), .i_ARLEN_M(arlen_m),
    .i_ARSIZE_M(arsize_m), .i_ARBURST_M(arburst_m), .i_ARVALID_M(arvalid_m),
    .o_ARREADY_M(arready_m), .o_RID_M(rid_m), .o_RDATA_M(rdata_m),
    .o_RRESP_M(rresp_m), .o_RLAST_M(rlast_m), .o_RVALID_M(rvalid_m),
    .i_RREADY_M(rready_m),
    .o_ARID_S(arid_s), .o_ARADDR_S(araddr_s), .o_ARLEN_S(arlen_s),
    .o_ARSIZE_S(arsize_s), .o_ARBURST_S(arburst_s), .o_ARVALID_S(arvalid_s),
    .i_ARREADY_S(arready_s), .i_RID_S(rid_s), .i_RDATA_S(rdata_s),
    .i_RRESP_S(rresp_s), .i_RLAST_S(rlast_s), .i_RVALID_S(rvalid_s),
    .o_RREADY_S(rready_s)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] t;
  } req_t;

  req_t mq0[$], mq1[$];
  int   n_tests = 0, n_fail = 0, cyc = 0;
  bit   rnd = 0, drop_rr = 0;

  // Reference model: phase 0 idle, 1 address, 2 data.
  int   ph = 0, mown = 0, mbeat = 0;
  bit   mlast = 1;
  req_t mcur;

  bit          sbusy[NS], srv[NS];
  logic [31:0] saddr[NS];
  logic [3:0]  slen[NS], sbeat[NS];
  logic [7:0]  sid[NS];
  int          sstall[NS];

  int rx_cnt[NM], ar0_cycles;
  int obs_glog[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int dec(input logic [31:0] a);
    if (a[31:16] == 16'h0000) return 0;
    if (a[31:16] == 16'h0001) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] beat_data(input int s, input logic [31:0] a, input logic [3:0] b);
    if (s == 2) return 32'h0;
    return a ^ {4{4'(s), b}} ^ 32'hC0DE_0000;
  endfunction

  function automatic int qsize(input int m);
    return (m == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic req_t head(input int m);
    return (m == 0) ? mq0[0] : mq1[0];
  endfunction

  task automatic enq(input int m, input logic [3:0] id, input logic [31:0] a,
                     input logic [3:0] len, input int delay);
    req_t r;
    r.id = id; r.addr = a; r.len = len;
    r.size = 3'($urandom % 3); r.burst = 2'($urandom % 3);
    r.t = 32'(cyc + delay);
    if (m == 0) mq0.push_back(r); else mq1.push_back(r);
  endtask

  task automatic drive();
    req_t h;
    for (int m = 0; m < NM; m++) begin
      if (qsize(m) > 0 && head(m).t <= 32'(cyc)) begin
        h = head(m);
        arvalid_m[m] = 1'b1; arid_m[m] = h.id; araddr_m[m] = h.addr;
        arlen_m[m] = h.len; arsize_m[m] = h.size; arburst_m[m] = h.burst;
      end else begin
        arvalid_m[m] = 1'b0; arid_m[m] = '0; araddr_m[m] = $urandom;
        arlen_m[m] = '0; arsize_m[m] = '0; arburst_m[m] = '0;
      end
      rready_m[m] = (rnd || drop_rr) ? ($urandom % 4 != 0) : 1'b1;
    end
    for (int s = 0; s < NS; s++) begin
      arready_s[s] = (sstall[s] == 0) && (rnd ? ($urandom % 2 == 0) : 1'b1);
      if (sbusy[s]) begin
        if (!srv[s]) srv[s] = rnd ? ($urandom % 3 != 0) : 1'b1;
        rvalid_s[s] = srv[s];
        rid_s[s]    = sid[s];
        rdata_s[s]  = beat_data(s, saddr[s], sbeat[s]);
        rresp_s[s]  = (s == 2) ? 2'b11 : 2'b00;
        rlast_s[s]  = (sbeat[s] == slen[s]);
      end else begin
        rvalid_s[s] = rnd && ($urandom % 4 == 0);
        rid_s[s] = 8'($urandom); rdata_s[s] = $urandom;
        rresp_s[s] = 2'($urandom); rlast_s[s] = 1'($urandom);
      end
    end
  endtask

  task automatic check_cycle();
    logic [NS-1:0] e_arv, e_rr;
    logic [NM-1:0] e_arr, e_rv;
    int es;
    e_arv = '0; e_rr = '0; e_arr = '0; e_rv = '0;
    es = (ph != 0) ? dec(mcur.addr) : 0;
    if (ph == 1) begin
      e_arv[es] = 1'b1;
      if (arready_s[es]) e_arr[mown] = 1'b1;
    end
    if (ph == 2) begin
      if (rvalid_s[es]) e_rv[mown] = 1'b1;
      if (rready_m[mown]) e_rr[es] = 1'b1;
    end
    check("arvalid_s", 64'(arvalid_s), 64'(e_arv));
    check("arready_m", 64'(arready_m), 64'(e_arr));
    check("rvalid_m", 64'(rvalid_m), 64'(e_rv));
    check("rready_s", 64'(rready_s), 64'(e_rr));
    for (int s = 0; s < NS; s++) begin
      if (e_arv[s])
        check("ar_payload", 64'({arid_s[s], araddr_s[s], arlen_s[s], arsize_s[s], arburst_s[s]}),
              64'({4'(mown), mcur.id, mcur.addr, mcur.len, mcur.size, mcur.burst}));
      else
        check("ar_zero", 64'({arid_s[s], araddr_s[s], arlen_s[s], arsize_s[s], arburst_s[s]}), 64'h0);
    end
    for (int m = 0; m < NM; m++) begin
      if (e_rv[m])
        check("r_beat", 64'({rid_m[m], rdata_m[m], rresp_m[m], rlast_m[m]}),
              64'({mcur.id, beat_data(es, mcur.addr, 4'(mbeat)),
                   (es == 2) ? 2'b11 : 2'b00, mbeat == int'(mcur.len)}));
      else
        check("r_zero", 64'({rid_m[m], rdata_m[m], rresp_m[m], rlast_m[m]}), 64'h0);
    end
  endtask

  task automatic update();
    int es;
    for (int m = 0; m < NM; m++) begin
      if (arvalid_m[m] && arready_m[m]) begin
        obs_glog.push_back(m);
        if (m == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
      end
      if (rvalid_m[m] && rready_m[m]) rx_cnt[m]++;
    end
    if (arvalid_s[0]) ar0_cycles++;
    for (int s = 0; s < NS; s++) begin
      if (arvalid_s[s] && !arready_s[s] && sstall[s] > 0) sstall[s]--;
      if (arvalid_s[s] && arready_s[s]) begin
        sbusy[s] = 1; srv[s] = 0; sbeat[s] = '0;
        saddr[s] = araddr_s[s]; slen[s] = arlen_s[s]; sid[s] = arid_s[s];
      end else if (sbusy[s] && rvalid_s[s] && rready_s[s]) begin
        srv[s] = 0;
        if (sbeat[s] == slen[s]) sbusy[s] = 0; else sbeat[s] = sbeat[s] + 4'd1;
      end
    end
    es = dec(mcur.addr);
    case (ph)
      0: if (|arvalid_m) begin
        mown = (&arvalid_m) ? int'(!mlast) : int'(arvalid_m[1]);
        mcur = head(mown);
        ph = 1;
      end
      1: if (arready_s[es]) begin ph = 2; mbeat = 0; end
      default: if (rvalid_s[es] && rready_m[mown]) begin
        if (mbeat == int'(mcur.len)) begin ph = 0; mlast = mown[0]; end
        else mbeat++;
      end
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    #1;
    check_cycle();
    update();
    cyc++;
  endtask

  task automatic run(input string tag, input int bound);
    int n = 0;
    while ((mq0.size() != 0 || mq1.size() != 0 || ph != 0) && n < bound) begin
      step();
      n++;
    end
    check(tag, 64'(n >= bound), 64'h0);
    repeat (2) step();
  endtask

  task automatic clear_obs();
    rx_cnt[0] = 0; rx_cnt[1] = 0; ar0_cycles = 0;
    obs_glog.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_arvalid_s", 64'(arvalid_s), 64'h0);
    check("rst_arready_m", 64'(arready_m), 64'h0);
    check("rst_rvalid_m", 64'(rvalid_m), 64'h0);
    check("rst_rready_s", 64'(rready_s), 64'h0);
    mq0.delete(); mq1.delete();
    ph = 0; mlast = 1; mbeat = 0;
    for (int s = 0; s < NS; s++) begin
      sbusy[s] = 0; srv[s] = 0; sstall[s] = 0;
    end
    arvalid_m = '0; rvalid_s = '0; arready_s = '0; rready_m = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int n, pick;
    int exp_beats[NM];
    logic [31:0] a;
    logic [3:0] l;
    arid_m = '0; araddr_m = '0; arlen_m = '0; arsize_m = '0; arburst_m = '0;
    arvalid_m = '0; rready_m = '0; arready_s = '0; rid_s = '0; rdata_s = '0;
    rresp_s = '0; rlast_s = '0; rvalid_s = '0;
    mcur = '0;
    #2;
    do_reset();

    // M0 4-beat burst to S0
    clear_obs();
    enq(0, 4'h5, 32'h0000_0040, 4'd3, 0);
    run("t1_timeout", 200);
    check("t1_m0_beats", 64'(rx_cnt[0]), 64'd4);

    // M1 single beat to S1
    clear_obs();
    enq(1, 4'hA, 32'h0001_0008, 4'd0, 0);
    run("t2_timeout", 200);
    check("t2_m1_beats", 64'(rx_cnt[1]), 64'd1);
    check("t2_m0_beats", 64'(rx_cnt[0]), 64'd0);

    // M1 decode error via S2
    clear_obs();
    enq(1, 4'h3, 32'h8000_0000, 4'd1, 0);
    run("t3_timeout", 200);
    check("t3_m1_beats", 64'(rx_cnt[1]), 64'd2);

    // Simultaneous requests, twice, straight after reset
    do_reset();
    clear_obs();
    enq(0, 4'h1, 32'h0000_0100, 4'd1, 0);
    enq(0, 4'h2, 32'h0001_0200, 4'd0, 0);
    enq(1, 4'h3, 32'h0001_0300, 4'd2, 0);
    enq(1, 4'h4, 32'h0000_0400, 4'd0, 0);
    run("t4_timeout", 400);
    check("t4_grants", 64'(obs_glog.size()), 64'd4);
    for (int i = 0; i < obs_glog.size() && i < 4; i++)
      check("t4_grant_order", 64'(obs_glog[i]), 64'(i % 2));
    check("t4_beats", 64'(rx_cnt[0] + rx_cnt[1]), 64'd7);

    // ARREADY stall on S0 and master RREADY back-pressure
    clear_obs();
    sstall[0] = 3; drop_rr = 1;
    enq(0, 4'h7, 32'h0000_0080, 4'd3, 0);
    run("t5_timeout", 400);
    drop_rr = 0;
    check("t5_ar_cycles", 64'(ar0_cycles), 64'd4);
    check("t5_m0_beats", 64'(rx_cnt[0]), 64'd4);

    // Reset during beat 2 of a 4-beat burst
    clear_obs();
    enq(0, 4'h9, 32'h0000_0010, 4'd3, 0);
    n = 0;
    while (!(ph == 2 && mbeat == 1) && n < 100) begin step(); n++; end
    check("t6_reach_beat2", 64'(n >= 100), 64'h0);
    do_reset();
    clear_obs();
    enq(1, 4'hB, 32'h0001_0044, 4'd2, 0);
    run("t6_timeout", 200);
    check("t6_m1_beats", 64'(rx_cnt[1]), 64'd3);
    check("t6_first_grant", 64'(obs_glog.size() > 0 ? obs_glog[0] : 9), 64'd1);

    // Randomized traffic from both masters
    clear_obs();
    rnd = 1;
    exp_beats[0] = 0; exp_beats[1] = 0;
    for (int i = 0; i < 60; i++) begin
      pick = $urandom % 3;
      a = $urandom;
      if (pick == 0) a[31:16] = 16'h0000;
      else if (pick == 1) a[31:16] = 16'h0001;
      else a[31] = 1'b1;
      l = 4'($urandom);
      enq(i % 2, 4'($urandom), a, l, $urandom % 40);
      exp_beats[i % 2] += int'(l) + 1;
    end
    run("rnd_timeout", 30000);
    check("rnd_m0_beats", 64'(rx_cnt[0]), 64'(exp_beats[0]));
    check("rnd_m1_beats", 64'(rx_cnt[1]), 64'(exp_beats[1]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
